score_bcd_digits: RTL and testbench

// - Upstream feeder for the score number-bitmap stage. Converts a binary game score into
//   NUM_DIGITS BCD digits with a sequential double-dabble, one shift per clk.
// - Commits new digits to the display only on startOfFrame, so a frame never shows mixed
//   old and new digits.
// - Output bus `digits` drives the bitmap stage's digit input directly: [2:0][3:0],

---
 rtl/score_bcd_digits.sv | 123 ++++++++++++
 tb/tb_score_bcd_digits.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_bcd_digits.sv
// Binary score to BCD digits using a sequential double-dabble (one shift per clock).
// New digits are committed to the display only on startOfFrame.
module score_bcd_digits #(
  parameter int BIN_W      = 10,
  parameter int NUM_DIGITS = 3,
  parameter int SAT_VALUE  = 999
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       score_valid,
  input  logic [BIN_W-1:0]           score,
  input  logic                       startOfFrame,
  output logic                       busy,
  output logic [NUM_DIGITS-1:0][3:0] digits,
  output logic                       digits_update,
  output logic                       overflow
);

  localparam int BCD_W = NUM_DIGITS * 4;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [BIN_W-1:0] SAT_B    = BIN_W'(SAT_VALUE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic                pend_full;
  logic                pend_sat;
  logic [BIN_W-1:0]    pend_val;
  logic [SR_W-1:0]     sr;
  logic                conv_sat;

  logic                in_sat;
  logic [BIN_W-1:0]    in_val;
  logic                load;
  logic                load_sat;
  logic [BIN_W-1:0]    load_val;
  logic                commit;

  function automatic logic [BIN_W-1:0] sat_val(input logic [BIN_W-1:0] s);
    return (s > SAT_B) ? SAT_B : s;
  endfunction

  // One double-dabble step: add 3 to every nibble >= 5, then shift left.
  // A nibble is at most 9 before the check, so the 4-bit add cannot carry out.
  function automatic logic [SR_W-1:0] dabble(input logic [SR_W-1:0] s);
    logic [SR_W-1:0] t;
    t = s;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (t[BIN_W + 4*i +: 4] >= 4'd5)
        t[BIN_W + 4*i +: 4] = t[BIN_W + 4*i +: 4] + 4'd3;
    end
    return {t[SR_W-2:0], 1'b0};
  endfunction

  assign in_sat   = (score > SAT_B);
  assign in_val   = sat_val(score);
  assign load     = (state == IDLE) && (score_valid || pend_full);
  assign load_val = score_valid ? in_val : pend_val;
  assign load_sat = score_valid ? in_sat : pend_sat;
  assign commit   = (state == HOLD) && startOfFrame;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      pend_full     <= 1'b0;
      busy          <= 1'b0;
      digits        <= '0;
      overflow      <= 1'b0;
      digits_update <= 1'b0;
    end else begin
      digits_update <= commit;
      if (load)
        pend_full <= 1'b0;
      else if (score_valid)
        pend_full <= 1'b1;
      case (state)
        IDLE: begin
          if (load) begin
            state <= SHIFT;
            cnt   <= CNT_LAST;
            busy  <= 1'b1;
          end else begin
            busy  <= 1'b0;
          end
        end
        SHIFT: begin
          cnt <= cnt - 1'b1;
          if (cnt == '0)
            state <= HOLD;
        end
        HOLD: begin
          if (commit) begin
            digits   <= sr[SR_W-1 -: BCD_W];
            overflow <= conv_sat;
            state    <= IDLE;
            // Stay busy when another value is queued; IDLE picks it up next cycle.
            busy     <= pend_full || score_valid;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath and pending value; validity is tracked by the control flags above.
  always_ff @(posedge clk) begin
    if (score_valid && !load) begin
      pend_val <= in_val;
      pend_sat <= in_sat;
    end
    if (load) begin
      sr       <= {{BCD_W{1'b0}}, load_val};
      conv_sat <= load_sat;
    end else if (state == SHIFT) begin
      sr <= dabble(sr);
    end
  end

endmodule

// File: tb/tb_score_bcd_digits.sv
// Randomized and directed bench for score_bcd_digits against a cycle-level behavioural model.
module tb_score_bcd_digits;

  logic             clk;
  logic             reset;
  logic             score_valid;
  logic [9:0]       score;
  logic             startOfFrame;
  logic             busy;
  logic [2:0][3:0]  digits;
  logic             digits_update;
  logic             overflow;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: phase 0 = waiting for a value, 1 = converting, 2 = result ready
  int   m_phase, m_left, m_val, m_pv;
  logic m_sat, m_ps, m_pend;
  int   e_val;
  logic e_ovf, e_upd, e_busy;

  score_bcd_digits #(.BIN_W(10), .NUM_DIGITS(3), .SAT_VALUE(999)) dut (
    .clk(clk), .reset(reset), .score_valid(score_valid), .score(score),
    .startOfFrame(startOfFrame), .busy(busy), .digits(digits),
    .digits_update(digits_update), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic model_reset();
    m_phase = 0; m_left = 0; m_val = 0; m_pv = 0;
    m_sat = 0; m_ps = 0; m_pend = 0;
    e_val = 0; e_ovf = 0; e_upd = 0; e_busy = 0;
  endtask

  task automatic model_step(input logic sv, input int sc, input logic sof);
    int   cv;
    logic cs;
    cs = (sc > 999);
    cv = cs ? 999 : sc;
    e_upd = 0;
    case (m_phase)
      0: begin
        if (sv) begin
          m_val = cv; m_sat = cs; m_phase = 1; m_left = 10; m_pend = 0;
        end else if (m_pend) begin
          m_val = m_pv; m_sat = m_ps; m_phase = 1; m_left = 10; m_pend = 0;
        end
      end
      1: begin
        if (sv) begin m_pv = cv; m_ps = cs; m_pend = 1; end
        m_left--;
        if (m_left == 0) m_phase = 2;
      end
      default: begin
        if (sof) begin
          e_val = m_val; e_ovf = m_sat; e_upd = 1; m_phase = 0;
        end
        if (sv) begin m_pv = cv; m_ps = cs; m_pend = 1; end
      end
    endcase
    e_busy = (m_phase != 0) || m_pend;
  endtask

  // Drive one cycle of inputs, clock it, advance the model, return 1 time unit after the edge.
  task automatic cycle(input logic sv, input logic [9:0] sc, input logic sof);
    score_valid  = sv;
    score        = sc;
    startOfFrame = sof;
    @(posedge clk);
    model_step(sv, int'(sc), sof);
    #1;
    score_valid  = 1'b0;
    startOfFrame = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; score_valid = 0; score = '0; startOfFrame = 0;
    model_reset();
    #3;
    n_checks++;
    if ({digits, overflow, busy, digits_update} !== 15'h0) begin
      n_fail++;
      $display("FAIL reset_state: got %h want %h", {digits, overflow, busy, digits_update}, 15'h0);
    end
    #4 reset = 1'b0;
  endtask

  task automatic test_zero();
    for (int i = 0; i < 14; i++) begin
      cycle(i == 0, 10'd0, i == 11);
      n_checks++;
      if ({digits, overflow, busy, digits_update} !== {to_bcd(e_val), e_ovf, e_busy, e_upd}) begin
        n_fail++;
        $display("FAIL zero cyc%0d: got %h want %h", i, {digits, overflow, busy, digits_update},
                 {to_bcd(e_val), e_ovf, e_busy, e_upd});
      end
      if (i == 11) begin
        n_checks++;
        if (digits_update !== 1'b1) begin
          n_fail++;
          $display("FAIL zero_update_pulse: got %b want 1", digits_update);
        end
      end
    end
  endtask

  task automatic test_early_sof();
    for (int i = 0; i < 44; i++) begin
      cycle(i == 0, 10'd987, (i == 5) || (i == 40));
      n_checks++;
      if ({digits, overflow, busy, digits_update} !== {to_bcd(e_val), e_ovf, e_busy, e_upd}) begin
        n_fail++;
        $display("FAIL early_sof cyc%0d: got %h want %h", i, {digits, overflow, busy, digits_update},
                 {to_bcd(e_val), e_ovf, e_busy, e_upd});
      end
      if (i == 6) begin
        n_checks++;
        if (digits !== 12'h000) begin
          n_fail++;
          $display("FAIL early_sof_ignored: got %h want 000", digits);
        end
      end
    end
    n_checks++;
    if (digits !== 12'h987) begin
      n_fail++;
      $display("FAIL early_sof_commit: got %h want 987", digits);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 30; i++) begin
      cycle((i == 0) || (i == 15), (i < 15) ? 10'd1023 : 10'd42, (i == 12) || (i == 27));
      n_checks++;
      if ({digits, overflow, busy, digits_update} !== {to_bcd(e_val), e_ovf, e_busy, e_upd}) begin
        n_fail++;
        $display("FAIL saturate cyc%0d: got %h want %h", i, {digits, overflow, busy, digits_update},
                 {to_bcd(e_val), e_ovf, e_busy, e_upd});
      end
      if (i == 13) begin
        n_checks++;
        if ({digits, overflow} !== {12'h999, 1'b1}) begin
          n_fail++;
          $display("FAIL saturate_999: got %h/%b want 999/1", digits, overflow);
        end
      end
    end
    n_checks++;
    if ({digits, overflow} !== {12'h042, 1'b0}) begin
      n_fail++;
      $display("FAIL saturate_then_42: got %h/%b want 042/0", digits, overflow);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 28; i++) begin
      cycle((i == 0) || (i == 4), (i == 0) ? 10'd123 : 10'd456, (i == 11) || (i == 25));
      n_checks++;
      if ({digits, overflow, busy, digits_update} !== {to_bcd(e_val), e_ovf, e_busy, e_upd}) begin
        n_fail++;
        $display("FAIL back_to_back cyc%0d: got %h want %h", i, {digits, overflow, busy, digits_update},
                 {to_bcd(e_val), e_ovf, e_busy, e_upd});
      end
      if (i < 25) begin
        n_checks++;
        if (busy !== 1'b1) begin
          n_fail++;
          $display("FAIL back_to_back_busy cyc%0d: got %b want 1", i, busy);
        end
      end
      if (i == 12) begin
        n_checks++;
        if (digits !== 12'h123) begin
          n_fail++;
          $display("FAIL back_to_back_first: got %h want 123", digits);
        end
      end
    end
    n_checks++;
    if (digits !== 12'h456) begin
      n_fail++;
      $display("FAIL back_to_back_second: got %h want 456", digits);
    end
  endtask

  task automatic test_same_cycle();
    for (int i = 0; i < 32; i++) begin
      cycle((i == 0) || (i == 11), (i == 0) ? 10'd77 : 10'd500, (i == 11) || (i == 30));
      n_checks++;
      if ({digits, overflow, busy, digits_update} !== {to_bcd(e_val), e_ovf, e_busy, e_upd}) begin
        n_fail++;
        $display("FAIL same_cycle cyc%0d: got %h want %h", i, {digits, overflow, busy, digits_update},
                 {to_bcd(e_val), e_ovf, e_busy, e_upd});
      end
      if (i == 11) begin
        n_checks++;
        if ({digits, busy} !== {12'h077, 1'b1}) begin
          n_fail++;
          $display("FAIL same_cycle_77: got %h/%b want 077/1", digits, busy);
        end
      end
    end
    n_checks++;
    if (digits !== 12'h500) begin
      n_fail++;
      $display("FAIL same_cycle_500: got %h want 500", digits);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 16; i++) begin
      cycle((i == 0) || (i == 12), (i == 0) ? 10'd654 : 10'd321, i == 11);
      n_checks++;
      if ({digits, overflow, busy, digits_update} !== {to_bcd(e_val), e_ovf, e_busy, e_upd}) begin
        n_fail++;
        $display("FAIL async_reset_pre cyc%0d: got %h want %h", i, {digits, overflow, busy, digits_update},
                 {to_bcd(e_val), e_ovf, e_busy, e_upd});
      end
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({digits, overflow, busy, digits_update} !== 15'h0) begin
      n_fail++;
      $display("FAIL async_reset_clear: got %h want %h", {digits, overflow, busy, digits_update}, 15'h0);
    end
    model_reset();
    #2 reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cycle(i == 0, 10'd5, i == 14);
      n_checks++;
      if ({digits, overflow, busy, digits_update} !== {to_bcd(e_val), e_ovf, e_busy, e_upd}) begin
        n_fail++;
        $display("FAIL async_reset_post cyc%0d: got %h want %h", i, {digits, overflow, busy, digits_update},
                 {to_bcd(e_val), e_ovf, e_busy, e_upd});
      end
    end
    n_checks++;
    if (digits !== 12'h005) begin
      n_fail++;
      $display("FAIL async_reset_then_5: got %h want 005", digits);
    end
  endtask

  task automatic test_random();
    logic       sv, sof;
    logic [9:0] sc;
    for (int i = 0; i < 800; i++) begin
      sv  = ($urandom_range(0, 5) == 0);
      sof = ($urandom_range(0, 8) == 0);
      sc  = 10'($urandom_range(0, 1023));
      cycle(sv, sc, sof);
      n_checks++;
      if ({digits, overflow, busy, digits_update} !== {to_bcd(e_val), e_ovf, e_busy, e_upd}) begin
        n_fail++;
        $display("FAIL random cyc%0d: got %h want %h", i, {digits, overflow, busy, digits_update},
                 {to_bcd(e_val), e_ovf, e_busy, e_upd});
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_early_sof();
    test_saturate();
    test_back_to_back();
    test_same_cycle();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
